// File: rtl/if_id_fetch_if.sv
// Instruction-memory fetch bus: the request is held with a stable address until a
// one-cycle ack returns the instruction word.
interface if_id_fetch_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/if_id_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register. Drives the pc register's
// write enable and sequences imem fetches under hazard stall and branch flush.
module if_id_fetch #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int PC_INC  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               pc_wr_enable,
  if_id_fetch_if.master      imem,
  input  logic               stall,
  input  logic               flush,
  output logic               ifid_valid,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_plus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  drop_addr_q, drop_addr_d;
  logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc_plus_q, ifid_pc_plus_d;

  // Sequential pc wraps naturally at the address width.
  assign pc_next      = pc + INC;
  assign ifid_valid   = ifid_valid_q;
  assign ifid_pc      = ifid_pc_q;
  assign ifid_instr   = ifid_instr_q;
  assign ifid_pc_plus = ifid_pc_plus_q;

  // Fetch FSM: next state, IF/ID load, hold/drop bookkeeping, bus and pc control.
  always_comb begin
    state_d        = state_q;
    drop_addr_d    = drop_addr_q;
    hold_pc_d      = hold_pc_q;
    hold_instr_d   = hold_instr_q;
    ifid_valid_d   = ifid_valid_q;
    ifid_pc_d      = ifid_pc_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_pc_plus_d = ifid_pc_plus_q;
    pc_wr_enable   = 1'b0;
    imem.req       = 1'b0;
    imem.addr      = pc;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (flush) begin
          ifid_valid_d = 1'b0;
          pc_wr_enable = 1'b1;
        end else begin
          pc_wr_enable = 1'b0;
        end
      end
      ST_FETCH: begin
        imem.req = 1'b1;
        if (flush) begin
          ifid_valid_d = 1'b0;
          pc_wr_enable = 1'b1;
          if (imem.ack) begin
            state_d = ST_FETCH;
          end else begin
            // The in-flight request must still be retired before fetching the target.
            drop_addr_d = pc;
            state_d     = ST_DROP;
          end
        end else if (imem.ack) begin
          if (stall) begin
            hold_pc_d    = pc;
            hold_instr_d = imem.data;
            state_d      = ST_HOLD;
          end else begin
            ifid_valid_d   = 1'b1;
            ifid_pc_d      = pc;
            ifid_instr_d   = imem.data;
            ifid_pc_plus_d = pc_next;
            pc_wr_enable   = 1'b1;
          end
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
        end else begin
          ifid_valid_d = ifid_valid_q;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          ifid_valid_d = 1'b0;
          pc_wr_enable = 1'b1;
          state_d      = ST_FETCH;
        end else if (stall) begin
          state_d = ST_HOLD;
        end else begin
          ifid_valid_d   = 1'b1;
          ifid_pc_d      = hold_pc_q;
          ifid_instr_d   = hold_instr_q;
          ifid_pc_plus_d = hold_pc_q + INC;
          pc_wr_enable   = 1'b1;
          state_d        = ST_FETCH;
        end
      end
      ST_DROP: begin
        imem.req  = 1'b1;
        imem.addr = drop_addr_q;
        if (flush) begin
          ifid_valid_d = 1'b0;
          pc_wr_enable = 1'b1;
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
        end else begin
          ifid_valid_d = ifid_valid_q;
        end
        if (imem.ack) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and IF/ID registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      drop_addr_q    <= '0;
      hold_pc_q      <= '0;
      hold_instr_q   <= '0;
      ifid_valid_q   <= 1'b0;
      ifid_pc_q      <= '0;
      ifid_instr_q   <= '0;
      ifid_pc_plus_q <= '0;
    end else begin
      state_q        <= state_d;
      drop_addr_q    <= drop_addr_d;
      hold_pc_q      <= hold_pc_d;
      hold_instr_q   <= hold_instr_d;
      ifid_valid_q   <= ifid_valid_d;
      ifid_pc_q      <= ifid_pc_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pc_plus_q <= ifid_pc_plus_d;
    end
  end

endmodule

// File: tb/tb_if_id_fetch.sv
// Directed scenarios followed by randomized traffic checked against a transaction-level
// model of the pc register, instruction memory and IF/ID contents.
module tb_if_id_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic        pc_wr_enable;
  logic        stall;
  logic        flush;
  logic        ifid_valid;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus;

  int n_pass  = 0;
  int n_total = 0;

  if_id_fetch_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  if_id_fetch #(.ADDR_W(16), .INSTR_W(16), .PC_INC(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_next      (pc_next),
    .pc_wr_enable (pc_wr_enable),
    .imem         (bus.master),
    .stall        (stall),
    .flush        (flush),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus (ifid_pc_plus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [15:0] p,
                          input logic [15:0] ins, input logic [15:0] pp);
    chk({tag, ".valid"}, 32'(ifid_valid), 32'(v));
    chk({tag, ".pc"}, 32'(ifid_pc), 32'(p));
    chk({tag, ".instr"}, 32'(ifid_instr), 32'(ins));
    chk({tag, ".pc_plus"}, 32'(ifid_pc_plus), 32'(pp));
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // random-phase model state
  logic [15:0] m_pc, raddr, pre_pc, tgt;
  logic [15:0] o_pc, o_instr, o_plus;
  logic        o_valid, pre_wr, pre_flush, pre_stall, busy, acked;
  int          wait_n;
  int          accepted;

  initial begin
    rst = 1'b1; pc = 16'h1100; stall = 1'b0; flush = 1'b0;
    bus.ack = 1'b0; bus.data = 16'h0000;

    // 1: reset held three cycles, then first request
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst.valid", 32'(ifid_valid), 32'd0);
      chk("rst.req", 32'(bus.req), 32'd0);
      chk("rst.wr_en", 32'(pc_wr_enable), 32'd0);
    end
    chk_ifid("rst.ifid", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    rst = 1'b0;
    cycle();
    chk("t1.req", 32'(bus.req), 32'd1);
    chk("t1.addr", 32'(bus.addr), 32'h1100);

    // 2: zero-wait stream
    bus.ack = 1'b1; bus.data = 16'hA000; #1;
    chk("t2.wr_en0", 32'(pc_wr_enable), 32'd1);
    chk("t2.pc_next", 32'(pc_next), 32'h1102);
    cycle();
    chk_ifid("t2.a", 1'b1, 16'h1100, 16'hA000, 16'h1102);
    pc = 16'h1102; bus.data = 16'hA001; #1;
    chk("t2.wr_en1", 32'(pc_wr_enable), 32'd1);
    cycle();
    chk_ifid("t2.b", 1'b1, 16'h1102, 16'hA001, 16'h1104);

    // 3: ack while stalled for three cycles
    pc = 16'h1206; stall = 1'b1; bus.data = 16'hB111; #1;
    chk("t3.wr_en_ack", 32'(pc_wr_enable), 32'd0);
    cycle();
    bus.ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3.req", 32'(bus.req), 32'd0);
      chk("t3.wr_en", 32'(pc_wr_enable), 32'd0);
      chk_ifid("t3.held", 1'b1, 16'h1102, 16'hA001, 16'h1104);
      cycle();
    end
    stall = 1'b0; #1;
    chk("t3.wr_en_rel", 32'(pc_wr_enable), 32'd1);
    cycle();
    chk_ifid("t3.rel", 1'b1, 16'h1206, 16'hB111, 16'h1208);
    chk("t3.req_after", 32'(bus.req), 32'd1);

    // 4: flush with a request outstanding
    pc = 16'h16A0; flush = 1'b1; #1;
    chk("t4.wr_en", 32'(pc_wr_enable), 32'd1);
    chk("t4.addr0", 32'(bus.addr), 32'h16A0);
    cycle();
    pc = 16'h7020; flush = 1'b0; #1;
    chk("t4.valid", 32'(ifid_valid), 32'd0);
    chk("t4.addr1", 32'(bus.addr), 32'h16A0);
    chk("t4.req1", 32'(bus.req), 32'd1);
    chk("t4.wr_en1", 32'(pc_wr_enable), 32'd0);
    cycle();
    chk("t4.addr2", 32'(bus.addr), 32'h16A0);
    bus.ack = 1'b1; bus.data = 16'hDEAD; #1;
    chk("t4.wr_en_ack", 32'(pc_wr_enable), 32'd0);
    cycle();
    bus.ack = 1'b0; #1;
    chk("t4.valid_after", 32'(ifid_valid), 32'd0);
    chk("t4.req_new", 32'(bus.req), 32'd1);
    chk("t4.addr_new", 32'(bus.addr), 32'h7020);

    // 5: pc wrap
    pc = 16'hFFFE; bus.ack = 1'b1; bus.data = 16'h9999; #1;
    chk("t5.pc_next", 32'(pc_next), 32'h0000);
    chk("t5.wr_en", 32'(pc_wr_enable), 32'd1);
    cycle();
    chk_ifid("t5", 1'b1, 16'hFFFE, 16'h9999, 16'h0000);

    // 6: stall and flush together while holding
    pc = 16'h3000; stall = 1'b1; bus.data = 16'hC0C0;
    cycle();
    bus.ack = 1'b0; flush = 1'b1; #1;
    chk("t6.wr_en", 32'(pc_wr_enable), 32'd1);
    cycle();
    chk("t6.valid", 32'(ifid_valid), 32'd0);
    chk("t6.req", 32'(bus.req), 32'd1);
    flush = 1'b0; stall = 1'b0; pc = 16'h4000;

    // reset in the middle of a fetch drops the request at once
    #1;
    chk("mid.req_before", 32'(bus.req), 32'd1);
    rst = 1'b1; #1;
    chk("mid.req", 32'(bus.req), 32'd0);
    chk("mid.valid", 32'(ifid_valid), 32'd0);
    cycle();
    rst = 1'b0;
    m_pc = 16'h0100; pc = m_pc;
    cycle();

    // randomized traffic
    busy = 1'b0; wait_n = 0; raddr = 16'h0000; accepted = 0;
    for (int n = 0; n < 1500; n++) begin
      pc    = m_pc;
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      tgt   = 16'($urandom) & 16'hFFFE;
      #1;
      if (bus.req) begin
        if (!busy) begin
          busy = 1'b1; wait_n = $urandom_range(0, 2); raddr = bus.addr;
        end else begin
          chk("rnd.addr_stable", 32'(bus.addr), 32'(raddr));
        end
      end
      acked = bus.req && busy && (wait_n == 0);
      bus.ack  = acked;
      bus.data = acked ? mem_word(raddr) : 16'($urandom);
      #1;
      chk("rnd.pc_next", 32'(pc_next), 32'(17'(pc) + 17'd2) & 32'hFFFF);
      if (flush) chk("rnd.wr_flush", 32'(pc_wr_enable), 32'd1);
      else if (stall) chk("rnd.wr_stall", 32'(pc_wr_enable), 32'd0);
      pre_pc = pc; pre_wr = pc_wr_enable; pre_flush = flush; pre_stall = stall;
      o_valid = ifid_valid; o_pc = ifid_pc; o_instr = ifid_instr; o_plus = ifid_pc_plus;
      cycle();
      if (acked) busy = 1'b0;
      else if (busy && wait_n > 0) wait_n = wait_n - 1;
      if (pre_flush) begin
        chk("rnd.flush_valid", 32'(ifid_valid), 32'd0);
      end else if (pre_wr) begin
        accepted = accepted + 1;
        chk_ifid("rnd.accept", 1'b1, pre_pc, mem_word(pre_pc), pre_pc + 16'd2);
      end else if (pre_stall) begin
        chk_ifid("rnd.stall_hold", o_valid, o_pc, o_instr, o_plus);
      end else begin
        chk("rnd.bubble", 32'(ifid_valid), 32'd0);
      end
      if (pre_wr) m_pc = pre_flush ? tgt : pre_pc + 16'd2;
    end
    bus.ack = 1'b0;
    chk("rnd.progress", 32'(accepted > 200), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
